// File: rtl/sparrow_dmem_responder_if.sv
// Request/response bus between the sparrow core's dmem port and the responder.
interface sparrow_dmem_responder_if;
  logic        i_req;
  logic        i_wr_en;
  logic [1:0]  i_byte_en;
  logic        i_zero_extend;
  logic [31:0] i_addr;
  logic [31:0] i_wr_data;
  logic        o_ready;
  logic        o_rvalid;
  logic [31:0] o_rdata;
  logic        o_err;

  modport master (
    output i_req, i_wr_en, i_byte_en, i_zero_extend, i_addr, i_wr_data,
    input  o_ready, o_rvalid, o_rdata, o_err
  );

  modport slave (
    input  i_req, i_wr_en, i_byte_en, i_zero_extend, i_addr, i_wr_data,
    output o_ready, o_rvalid, o_rdata, o_err
  );
endinterface

// File: rtl/sparrow_dmem_responder.sv
// Word-organised data memory with byte/half/word access, sign/zero extension,
// configurable wait states and a one-cycle response pulse.
//
// state  | meaning
// IDLE   | ready for a new request
// WAIT   | request latched, counting down wait states
// RESP   | response cycle, o_rvalid high
module sparrow_dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  sparrow_dmem_responder_if.slave bus
);

  localparam int AW   = $clog2(DEPTH_WORDS);
  localparam int WSM1 = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic        wr_en_q;
  logic [1:0]  size_q;
  logic        zext_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        rvalid_q;
  logic        err_q;
  logic [31:0] rdata_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic        accept;
  logic        commit;
  logic        cur_we;
  logic [1:0]  cur_size;
  logic        cur_zext;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic [AW-1:0] cur_idx;
  logic        cur_err;
  logic [31:0] rd_word;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] load_data;
  logic [3:0]  lane_en;
  logic [31:0] wr_word;

  assign bus.o_ready  = (state == S_IDLE);
  assign bus.o_rvalid = rvalid_q;
  assign bus.o_rdata  = rdata_q;
  assign bus.o_err    = err_q;

  assign accept = bus.i_req && (state == S_IDLE);
  // With zero wait states the access commits on the accept edge itself,
  // so it must be served from the live inputs rather than the latched copy.
  assign commit = (accept && (WAIT_STATES == 0)) || ((state == S_WAIT) && (cnt == 4'd0));

  // Select live request fields while idle, latched ones otherwise.
  always_comb begin
    cur_we    = wr_en_q;
    cur_size  = size_q;
    cur_zext  = zext_q;
    cur_addr  = addr_q;
    cur_wdata = wdata_q;
    if (state == S_IDLE) begin
      cur_we    = bus.i_wr_en;
      cur_size  = bus.i_byte_en;
      cur_zext  = bus.i_zero_extend;
      cur_addr  = bus.i_addr;
      cur_wdata = bus.i_wr_data;
    end
  end

  // Address decode and error classification.
  always_comb begin
    cur_idx = cur_addr[AW+1:2];
    cur_err = (|cur_addr[31:AW+2]);
    case (cur_size)
      2'b00:   cur_err = cur_err;
      2'b01:   cur_err = cur_err | cur_addr[0];
      2'b10:   cur_err = cur_err | (|cur_addr[1:0]);
      default: cur_err = 1'b1;
    endcase
  end

  // Load path: pick the lane and extend it.
  always_comb begin
    rd_word = mem[cur_idx];
    byte_v  = rd_word[{cur_addr[1:0], 3'b000} +: 8];
    half_v  = cur_addr[1] ? rd_word[31:16] : rd_word[15:0];
    case (cur_size)
      2'b00:   load_data = {{24{~cur_zext & byte_v[7]}}, byte_v};
      2'b01:   load_data = {{16{~cur_zext & half_v[15]}}, half_v};
      default: load_data = rd_word;
    endcase
  end

  // Store path: lane enables and data replicated into every lane.
  always_comb begin
    case (cur_size)
      2'b00: begin
        lane_en = 4'b0001 << cur_addr[1:0];
        wr_word = {4{cur_wdata[7:0]}};
      end
      2'b01: begin
        lane_en = cur_addr[1] ? 4'b1100 : 4'b0011;
        wr_word = {2{cur_wdata[15:0]}};
      end
      default: begin
        lane_en = 4'b1111;
        wr_word = cur_wdata;
      end
    endcase
  end

  // RAM write on the commit edge; the RAM itself is never reset.
  always_ff @(posedge i_clk) begin
    if (commit && cur_we && !cur_err && !i_rst) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_en[i]) mem[cur_idx][8*i +: 8] <= wr_word[8*i +: 8];
      end
    end
  end

  // Sequencer, request latch and registered response.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= S_IDLE;
      cnt      <= 4'd0;
      wr_en_q  <= 1'b0;
      size_q   <= 2'b00;
      zext_q   <= 1'b0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= 32'd0;
    end else begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      if (commit) begin
        rvalid_q <= 1'b1;
        err_q    <= cur_err;
        rdata_q  <= (cur_err || cur_we) ? 32'd0 : load_data;
      end
      case (state)
        S_IDLE: begin
          if (accept) begin
            wr_en_q <= bus.i_wr_en;
            size_q  <= bus.i_byte_en;
            zext_q  <= bus.i_zero_extend;
            addr_q  <= bus.i_addr;
            wdata_q <= bus.i_wr_data;
            cnt     <= WSM1[3:0];
            state   <= (WAIT_STATES == 0) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt == 4'd0) state <= S_RESP;
          else             cnt   <= cnt - 4'd1;
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sparrow_dmem_responder.sv
// Bench for sparrow_dmem_responder: three instances (0, 1 and 3 wait states)
// share one stimulus bus; a byte-level memory model predicts every response.
module tb_sparrow_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  int          sel;
  logic        we;
  logic [1:0]  sz;
  logic        ze;
  logic [31:0] addr;
  logic [31:0] wd;

  always #5 clk = ~clk;

  sparrow_dmem_responder_if b0 ();
  sparrow_dmem_responder_if b1 ();
  sparrow_dmem_responder_if b3 ();

  assign b0.i_req = req && (sel == 0);
  assign b1.i_req = req && (sel == 1);
  assign b3.i_req = req && (sel == 2);
  assign b0.i_wr_en = we;  assign b1.i_wr_en = we;  assign b3.i_wr_en = we;
  assign b0.i_byte_en = sz; assign b1.i_byte_en = sz; assign b3.i_byte_en = sz;
  assign b0.i_zero_extend = ze; assign b1.i_zero_extend = ze; assign b3.i_zero_extend = ze;
  assign b0.i_addr = addr; assign b1.i_addr = addr; assign b3.i_addr = addr;
  assign b0.i_wr_data = wd; assign b1.i_wr_data = wd; assign b3.i_wr_data = wd;

  sparrow_dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) dut0 (.i_clk(clk), .i_rst(rst), .bus(b0.slave));
  sparrow_dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(1)) dut1 (.i_clk(clk), .i_rst(rst), .bus(b1.slave));
  sparrow_dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(3)) dut3 (.i_clk(clk), .i_rst(rst), .bus(b3.slave));

  logic        rdy [3];
  logic        rv  [3];
  logic        er  [3];
  logic [31:0] rd  [3];
  assign rdy[0] = b0.o_ready;  assign rdy[1] = b1.o_ready;  assign rdy[2] = b3.o_ready;
  assign rv[0]  = b0.o_rvalid; assign rv[1]  = b1.o_rvalid; assign rv[2]  = b3.o_rvalid;
  assign er[0]  = b0.o_err;    assign er[1]  = b1.o_err;    assign er[2]  = b3.o_err;
  assign rd[0]  = b0.o_rdata;  assign rd[1]  = b1.o_rdata;  assign rd[2]  = b3.o_rdata;

  int ntests = 0;
  int nfail  = 0;
  int cyc    = 0;
  int wsv [3] = '{0, 1, 3};
  int rvcnt [3] = '{0, 0, 0};

  // model state
  bit          pend [3];
  int          left [3];
  bit          xrv  [3];
  bit          xer  [3];
  logic [31:0] xrd  [3];
  bit          lw [3];
  logic [1:0]  ls [3];
  bit          lz [3];
  logic [31:0] la [3];
  logic [31:0] ld [3];
  logic [31:0] mem [int];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit is_err(logic [1:0] s, logic [31:0] a);
    int nb;
    if (s == 2'b11) return 1'b1;
    if (a >= 32'd4096) return 1'b1;
    nb = 1 << s;
    return (a % nb) != 0;
  endfunction

  // Apply one access to the model memory and set the expected response.
  function automatic void model_commit(int k, bit w, logic [1:0] s, bit z, logic [31:0] a, logic [31:0] d);
    int key;
    int nb;
    int lane;
    logic [31:0] word;
    logic [31:0] v;
    key = k * 2048 + int'(a[11:2]);
    xrv[k] = 1'b1;
    xrd[k] = 32'd0;
    xer[k] = is_err(s, a);
    if (xer[k]) return;
    nb = 1 << s;
    word = mem.exists(key) ? mem[key] : 32'd0;
    if (w) begin
      for (int b = 0; b < nb; b++) begin
        lane = int'(a % 4) + b;
        word[8*lane +: 8] = d[8*b +: 8];
      end
      mem[key] = word;
    end else begin
      v = word >> (8 * (a % 4));
      if (s == 2'b00) v = z ? (v & 32'hFF) : {{24{v[7]}}, v[7:0]};
      else if (s == 2'b01) v = z ? (v & 32'hFFFF) : {{16{v[15]}}, v[15:0]};
      xrd[k] = v;
    end
  endfunction

  // Model advance on each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      for (int k = 0; k < 3; k++) begin
        if (rst) begin
          pend[k] = 1'b0;
          xrv[k]  = 1'b0;
        end else if (xrv[k]) begin
          xrv[k] = 1'b0;
        end else if (pend[k]) begin
          left[k]--;
          if (left[k] == 0) begin
            pend[k] = 1'b0;
            model_commit(k, lw[k], ls[k], lz[k], la[k], ld[k]);
          end
        end else if (req && sel == k) begin
          lw[k] = we; ls[k] = sz; lz[k] = ze; la[k] = addr; ld[k] = wd;
          if (wsv[k] == 0) model_commit(k, we, sz, ze, addr, wd);
          else begin
            pend[k] = 1'b1;
            left[k] = wsv[k];
          end
        end
      end
    end
  end

  // Per-cycle compare of all three instances against the model.
  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (rv[k] === 1'b1) rvcnt[k]++;
        if (rst) begin
          pend[k] = 1'b0;
          xrv[k]  = 1'b0;
          chk($sformatf("rst_ready%0d", k), 32'(rdy[k]), 32'd1);
          chk($sformatf("rst_rvalid%0d", k), 32'(rv[k]), 32'd0);
          chk($sformatf("rst_err%0d", k), 32'(er[k]), 32'd0);
          chk($sformatf("rst_rdata%0d", k), rd[k], 32'd0);
        end else begin
          chk($sformatf("ready%0d", k), 32'(rdy[k]), 32'(!pend[k] && !xrv[k]));
          chk($sformatf("rvalid%0d", k), 32'(rv[k]), 32'(xrv[k]));
          if (xrv[k]) begin
            chk($sformatf("rdata%0d", k), rd[k], xrd[k]);
            chk($sformatf("err%0d", k), 32'(er[k]), 32'(xer[k]));
          end else begin
            chk($sformatf("err_idle%0d", k), 32'(er[k]), 32'd0);
          end
        end
      end
    end
  end

  task automatic access(input int k, input bit w, input logic [1:0] s, input bit z,
                        input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rdata, output logic rerr, output int lat);
    int t;
    int acc;
    sel = k; we = w; sz = s; ze = z; addr = a; wd = d; req = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!rdy[k] && t < 50);
    if (!rdy[k]) chk("accept_timeout", 32'(t), 32'd0);
    acc = cyc;
    @(posedge clk);
    #1 req = 1'b0;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!rv[k] && t < 50);
    if (!rv[k]) chk("rvalid_timeout", 32'(t), 32'd0);
    rdata = rd[k];
    rerr  = er[k];
    lat   = cyc - acc;
  endtask

  logic [31:0] r;
  logic        e;
  int          lat;
  int          accs [4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req = 1'b0; sel = 1; we = 1'b0; sz = 2'b00; ze = 1'b0; addr = '0; wd = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // 1: word store / load, one wait state
    access(1, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, r, e, lat);
    chk("t1_store_lat", 32'(lat), 32'd2);
    chk("t1_store_rdata", r, 32'd0);
    chk("t1_store_err", 32'(e), 32'd0);
    @(negedge clk);
    chk("t1_ready_after", 32'(rdy[1]), 32'd1);
    access(1, 0, 2'b10, 0, 32'h10, 32'h0, r, e, lat);
    chk("t1_load_word", r, 32'hDEADBEEF);

    // 2: sub-word loads
    access(1, 0, 2'b00, 0, 32'h13, 32'h0, r, e, lat); chk("t2_lb_sext", r, 32'hFFFFFFDE);
    access(1, 0, 2'b00, 1, 32'h13, 32'h0, r, e, lat); chk("t2_lb_zext", r, 32'h000000DE);
    access(1, 0, 2'b01, 0, 32'h10, 32'h0, r, e, lat); chk("t2_lh_sext", r, 32'hFFFFBEEF);
    access(1, 0, 2'b01, 1, 32'h12, 32'h0, r, e, lat); chk("t2_lh_zext", r, 32'h0000DEAD);

    // 3: sub-word stores merge into the old word
    access(1, 1, 2'b00, 0, 32'h11, 32'h00000055, r, e, lat);
    access(1, 0, 2'b10, 0, 32'h10, 32'h0, r, e, lat); chk("t3_sb_merge", r, 32'hDEAD55EF);
    access(1, 1, 2'b01, 0, 32'h12, 32'h00001234, r, e, lat);
    access(1, 0, 2'b10, 0, 32'h10, 32'h0, r, e, lat); chk("t3_sh_merge", r, 32'h123455EF);

    // 4: error cases leave memory untouched
    access(1, 1, 2'b10, 0, 32'h20, 32'hCAFEF00D, r, e, lat);
    access(1, 1, 2'b10, 0, 32'h0,  32'h01020304, r, e, lat);
    access(1, 1, 2'b10, 0, 32'h12, 32'hFFFFFFFF, r, e, lat);
    chk("t4_mis_word_err", 32'(e), 32'd1); chk("t4_mis_word_rdata", r, 32'd0);
    access(1, 1, 2'b01, 0, 32'h21, 32'hFFFFFFFF, r, e, lat);
    chk("t4_mis_half_err", 32'(e), 32'd1);
    access(1, 1, 2'b11, 0, 32'h10, 32'hFFFFFFFF, r, e, lat);
    chk("t4_size11_err", 32'(e), 32'd1);
    access(1, 0, 2'b11, 0, 32'h10, 32'h0, r, e, lat);
    chk("t4_size11_load_err", 32'(e), 32'd1); chk("t4_size11_load_rdata", r, 32'd0);
    access(1, 1, 2'b10, 0, 32'h1000, 32'hFFFFFFFF, r, e, lat);
    chk("t4_range_err", 32'(e), 32'd1);
    access(1, 0, 2'b10, 0, 32'h10, 32'h0, r, e, lat); chk("t4_keep_10", r, 32'h123455EF);
    access(1, 0, 2'b10, 0, 32'h20, 32'h0, r, e, lat); chk("t4_keep_20", r, 32'hCAFEF00D);
    access(1, 0, 2'b10, 0, 32'h0,  32'h0, r, e, lat); chk("t4_keep_00", r, 32'h01020304);

    // 5: zero wait states, back-to-back; then three wait states
    for (int i = 0; i < 4; i++) begin
      access(0, 1, 2'b10, 0, 32'(i * 4), 32'h1000_0000 + 32'(i), r, e, lat);
      chk("t5_ws0_lat", 32'(lat), 32'd1);
    end
    begin
      int base;
      int t;
      base = rvcnt[0];
      sel = 0; we = 1'b0; sz = 2'b10; ze = 1'b0; req = 1'b1;
      for (int i = 0; i < 4; i++) begin
        addr = 32'(i * 4);
        t = 0;
        do begin
          @(negedge clk);
          t++;
        end while (!rdy[0] && t < 20);
        accs[i] = cyc;
        @(posedge clk);
        #1;
      end
      req = 1'b0;
      repeat (3) @(negedge clk);
      for (int i = 1; i < 4; i++) chk("t5_b2b_spacing", 32'(accs[i] - accs[i-1]), 32'd2);
      chk("t5_b2b_count", 32'(rvcnt[0] - base), 32'd4);
    end
    access(2, 1, 2'b10, 0, 32'h80, 32'h89ABCDEF, r, e, lat);
    chk("t5_ws3_store_lat", 32'(lat), 32'd4);
    access(2, 0, 2'b01, 0, 32'h82, 32'h0, r, e, lat);
    chk("t5_ws3_load_lat", 32'(lat), 32'd4);
    chk("t5_ws3_lh", r, 32'hFFFF89AB);

    // 6: reset during WAIT drops the store
    access(1, 1, 2'b10, 0, 32'h40, 32'h11223344, r, e, lat);
    @(posedge clk);
    #1;
    sel = 1; we = 1'b1; sz = 2'b10; addr = 32'h40; wd = 32'hA5A5A5A5; req = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;
    chk("t6_in_wait", 32'(rdy[1]), 32'd0);
    rst = 1'b1;
    #1;
    chk("t6_rst_rvalid", 32'(rv[1]), 32'd0);
    chk("t6_rst_rdata", rd[1], 32'd0);
    chk("t6_rst_err", 32'(er[1]), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    begin
      int base;
      base = rvcnt[1];
      repeat (4) @(negedge clk);
      chk("t6_ready_after_rst", 32'(rdy[1]), 32'd1);
      chk("t6_no_stray_rvalid", 32'(rvcnt[1] - base), 32'd0);
    end
    access(1, 0, 2'b10, 0, 32'h40, 32'h0, r, e, lat);
    chk("t6_no_commit", r, 32'h11223344);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/sparrow_dmem_responder.md
Name: sparrow_dmem_responder

Overview:
Data-memory responder for the sparrow core. It serves the dmem request interface driven by the decoded controls: dmem_req, dmem_wr_en, dmem_byte_en and dmem_zero_extend, plus the ALU-computed address and rs2 store data.
- Holds a word-organised RAM.
- Performs byte, half-word and word accesses with lane alignment and sign/zero extension.
- Returns a single-cycle response after a configurable number of wait states.
- Flags misaligned or out-of-range accesses.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in the RAM; must be a power of two.
WAIT_STATES, 1, extra cycles between request acceptance and response; legal range 0..15.

Ports:
i_clk  input  1  clock; all state updates on the rising edge.
i_rst  input  1  asynchronous, active-high reset.
i_req  input  1  request valid; maps to dmem_req.
i_wr_en  input  1  1 = store, 0 = load.
i_byte_en  input  2  access size: 00 byte, 01 half-word, 10 word, 11 reserved.
i_zero_extend  input  1  selects load extension: 1 = zero-extend, 0 = sign-extend; ignored for stores and word loads.
i_addr  input  32  byte address.
i_wr_data  input  32  store data; the low byte/half/word is used according to size.
o_ready  output  1  responder can accept a request this cycle.
o_rvalid  output  1  response valid; one-cycle pulse.
o_rdata  output  32  extended load data; 0 for stores and errors.
o_err  output  1  qualified by o_rvalid: misaligned, reserved size, or out-of-range access.

Behaviour:
- Reset (asynchronous, i_rst=1): state IDLE, wait counter 0, o_rvalid=0, o_rdata=0, o_err=0. RAM contents are not reset.
- o_ready is combinational and equals (state==IDLE).
- Acceptance: a request is accepted on the rising edge where i_req && o_ready. On that edge the responder latches i_wr_en, i_byte_en, i_zero_extend, i_addr and i_wr_data. i_req while o_ready=0 is ignored; the requester must hold the request until accepted.
- States:
  - IDLE: on accept, go to WAIT if WAIT_STATES>0, else go directly to RESP. Load the counter with WAIT_STATES-1.
  - WAIT: decrement the counter each cycle. When the counter reaches 0, go to RESP.
  - RESP: always returns to IDLE on the next edge.
- Commit point: on the edge entering RESP, stores write the RAM and loads register o_rdata. o_rvalid=1 exactly during the RESP cycle.
- Latency: accepted in cycle N gives o_rvalid in cycle N+1+WAIT_STATES, and o_ready high again in cycle N+2+WAIT_STATES. Throughput is one access per WAIT_STATES+2 cycles.
- Address decode: word index = addr[log2(DEPTH_WORDS)+1:2]; lane = addr[1:0].
- Error conditions:
  - half-word with addr[0]=1;
  - word with addr[1:0]!=00;
  - size 11;
  - addr[31:log2(DEPTH_WORDS)+2] nonzero.
- On error: no RAM write, o_rdata=0, o_err=1 in the RESP cycle.
- Loads:
  - byte: lane byte addr[1:0], extended from bit 7.
  - half-word: lane half addr[1], extended from bit 15.
  - word: returned unmodified.
- Stores:
  - byte: write only byte lane addr[1:0] with wr_data[7:0].
  - half-word: write only half addr[1] with wr_data[15:0].
  - word: write all 4 lanes.
  - Unwritten lanes keep their old values.
- o_rdata holds its value between responses; it is only meaningful while o_rvalid=1.
- Stores: o_rvalid pulses as an ack with o_rdata=0, o_err=0.
- Reset mid-operation: a pending access is dropped, and the RAM is unchanged if reset asserts before the commit edge. No response is issued after reset releases.
- o_err and o_rvalid are 0 in every non-RESP cycle.

Test Plan:
1. WAIT_STATES=1. Store word 0xDEADBEEF @0x10 accepted in cycle 5 -> o_rvalid=1 in cycle 7 with o_rdata=0, o_err=0; o_ready=0 in cycles 6-7, 1 in cycle 8. Then load word @0x10 -> o_rdata=0xDEADBEEF.
2. After test 1: load byte @0x13, sign-extend -> 0xFFFFFFDE. Load byte @0x13, zero-extend -> 0x000000DE. Load half @0x10, sign-extend -> 0xFFFFBEEF. Load half @0x12, zero-extend -> 0x0000DEAD.
3. Store byte 0x55 @0x11 over 0xDEADBEEF -> word load @0x10 returns 0xDEAD55EF. Store half 0x1234 @0x12 -> word load returns 0x123455EF.
4. Store word @0x12 (misaligned), half @0x21, size 11, and addr 0x00001000 with DEPTH_WORDS=1024 -> each responds with o_err=1, o_rdata=0. Subsequent reads of the targeted words are unchanged.
5. WAIT_STATES=0. Four back-to-back loads with i_req held high -> accepted every 2nd cycle, each o_rvalid exactly 1 cycle after accept. WAIT_STATES=3 -> o_rvalid 4 cycles after accept.
6. Store word 0xA5A5A5A5 @0x40 accepted. Assert i_rst in the WAIT cycle -> o_rvalid, o_rdata and o_err go 0 immediately and o_ready=1 after release. Load @0x40 returns its prior value (no commit), and no stray o_rvalid appears.
